uart_boot_loader: RTL and testbench

Sequences the on-chip RAM write port from the UART receive FIFO at power-up, so firmware loads over serial instead of being baked into the bitstream. It holds the CPU in reset, reads a length-prefixed little-endian image byte by byte, packs each four bytes into a word, and writes the words to RAM from word 0 upward. It then releases the CPU. It sits in `top` between the `uart` read side and the `ram` port; `top` muxes RAM `addr`/`din`/`we` to this block while `busy` is high.

---
 rtl/boot_pkg.sv | 20 ++
 rtl/word_packer.sv | 38 +++
 rtl/uart_boot_loader.sv | 160 ++++++++++++++++
 tb/tb_uart_boot_loader.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader.
// The CSUM state exists only when UART_BOOT_LOADER_CHECKSUM_EN is defined.
package boot_pkg;

  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;
  localparam int BYTE_W     = 8;

  typedef enum logic [2:0] {
    HDR,
    DATA,
    WRITE,
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/word_packer.sv
// Little-endian byte-to-word packer shared by the header and payload paths.
// word_full pulses for one cycle after every fourth byte strobe.
module word_packer
  import boot_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [31:0]       word,
  output logic              word_full
);

  localparam int PACK_BYTES = (HDR_BYTES > WORD_BYTES) ? HDR_BYTES : WORD_BYTES;

  logic [1:0]  cnt_reg;
  logic [31:0] word_reg;
  logic        full_reg;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_reg  <= '0;
      word_reg <= '0;
      full_reg <= 1'b0;
    end else begin
      full_reg <= byte_en && (cnt_reg == 2'(PACK_BYTES - 1));
      if (byte_en) begin
        cnt_reg  <= cnt_reg + 2'd1;
        // Shift in from the top so the first byte lands in [7:0] after four strobes.
        word_reg <= {byte_in, word_reg[31:BYTE_W]};
      end
    end
  end

  assign word      = word_reg;
  assign word_full = full_reg;

endmodule

// File: rtl/uart_boot_loader.sv
// Loads a length-prefixed little-endian image from the UART RX FIFO into RAM, then releases the CPU.
// Define UART_BOOT_LOADER_CHECKSUM_EN to require a trailing mod-256 payload checksum byte.
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int NUM_WORDS = 3584,
  parameter int ADDR_W    = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_empty,
  input  logic [7:0]        uart_rdata,
  output logic              rd_uart,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_we,
  output logic              busy,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

`ifdef UART_BOOT_LOADER_CHECKSUM_EN
  localparam state_t AFTER_LOAD = CSUM;
`else
  localparam state_t AFTER_LOAD = DONE;
`endif

  state_t            state_reg;
  logic [31:0]       n_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic              pop_reg;
  logic [ADDR_W-1:0] ram_addr_reg;
  logic [31:0]       ram_wdata_reg;
  logic [3:0]        ram_we_reg;
  logic              busy_reg;
  logic              cpu_reset_reg;
  logic              done_reg;
  logic              error_reg;
  logic              accept;
  logic              pop;
  logic [31:0]       word;
  logic              word_full;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
  logic [7:0]        sum_reg;
`endif

  // Pops are spaced by a forced idle cycle so the FIFO head has time to advance.
  always_comb begin
    accept = (state_reg == HDR) || (state_reg == DATA);
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    if (state_reg == CSUM) accept = 1'b1;
`endif
    pop = accept && !rx_empty && !pop_reg;
  end

  word_packer u_packer (
    .clk       (clk),
    .clr       (reset),
    .byte_en   (pop),
    .byte_in   (uart_rdata),
    .word      (word),
    .word_full (word_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= HDR;
      n_reg         <= '0;
      idx_reg       <= '0;
      pop_reg       <= 1'b0;
      ram_addr_reg  <= '0;
      ram_wdata_reg <= '0;
      ram_we_reg    <= '0;
      busy_reg      <= 1'b1;
      cpu_reset_reg <= 1'b1;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
      sum_reg       <= '0;
`endif
    end else begin
      pop_reg    <= pop;
      ram_we_reg <= '0;
      case (state_reg)
        HDR: begin
          if (word_full) begin
            n_reg <= word;
            if (word > 32'(NUM_WORDS)) begin
              state_reg <= ERR;
              error_reg <= 1'b1;
            end else if (word == 32'd0) begin
              state_reg <= AFTER_LOAD;
              if (AFTER_LOAD == DONE) begin
                busy_reg      <= 1'b0;
                cpu_reset_reg <= 1'b0;
                done_reg      <= 1'b1;
              end
            end else begin
              state_reg <= DATA;
            end
          end
        end
        DATA: begin
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
          if (pop) sum_reg <= sum_reg + uart_rdata;
`endif
          if (word_full) begin
            state_reg     <= WRITE;
            ram_we_reg    <= 4'b1111;
            ram_addr_reg  <= idx_reg;
            ram_wdata_reg <= word;
          end
        end
        WRITE: begin
          idx_reg <= idx_reg + 1'b1;
          if (32'(idx_reg) + 32'd1 == n_reg) begin
            state_reg <= AFTER_LOAD;
            if (AFTER_LOAD == DONE) begin
              busy_reg      <= 1'b0;
              cpu_reset_reg <= 1'b0;
              done_reg      <= 1'b1;
            end
          end else begin
            state_reg <= DATA;
          end
        end
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
        CSUM: begin
          // The trailing byte sits in the packer's top lane the cycle after its pop.
          if (pop_reg) begin
            if (word[31:24] == sum_reg) begin
              state_reg     <= DONE;
              busy_reg      <= 1'b0;
              cpu_reset_reg <= 1'b0;
              done_reg      <= 1'b1;
            end else begin
              state_reg <= ERR;
              error_reg <= 1'b1;
            end
          end
        end
`endif
        DONE:    state_reg <= DONE;
        ERR:     state_reg <= ERR;
        default: state_reg <= HDR;
      endcase
    end
  end

  assign rd_uart   = pop;
  assign ram_addr  = ram_addr_reg;
  assign ram_wdata = ram_wdata_reg;
  assign ram_we    = ram_we_reg;
  assign busy      = busy_reg;
  assign cpu_reset = cpu_reset_reg;
  assign done      = done_reg;
  assign error     = error_reg;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: FIFO and RAM models driven from one sequential initial block.
module tb_uart_boot_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_empty = 1'b1;
  logic [7:0]  uart_rdata = 8'h00;
  logic        rd_uart;
  logic [29:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_we;
  logic        busy, cpu_reset, done, error;

  logic [7:0]  q[$];
  logic [31:0] ram_m [0:15];
  int          popped, writes, viol, bad_we;
  int          vectors, miscompares;
  int          cycles;
  logic        prev_pop;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
  localparam int CS = 2;
`else
  localparam int CS = 0;
`endif

  uart_boot_loader dut (
    .clk        (clk),
    .reset      (reset),
    .rx_empty   (rx_empty),
    .uart_rdata (uart_rdata),
    .rd_uart    (rd_uart),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .busy       (busy),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample DUT between edges, apply the edge to the FIFO/RAM models.
  task automatic step();
    logic        p;
    logic [3:0]  we;
    logic [29:0] a;
    logic [31:0] d;
    #1;
    p = rd_uart; we = ram_we; a = ram_addr; d = ram_wdata;
    @(posedge clk);
    if (p) begin
      if (prev_pop) viol++;
      if (q.size() > 0) void'(q.pop_front());
      popped++;
    end
    prev_pop = p;
    if (we != 4'h0) begin
      writes++;
      if (we != 4'hF) bad_we++;
      if (a < 30'd16) ram_m[a[3:0]] = d;
    end
    #1;
    rx_empty   = (q.size() == 0);
    uart_rdata = rx_empty ? 8'h00 : q[0];
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    rx_empty   = 1'b0;
    uart_rdata = q[0];
  endtask

  task automatic start_test();
    q.delete();
    rx_empty = 1'b1; uart_rdata = 8'h00;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    popped = 0; writes = 0; viol = 0; bad_we = 0; prev_pop = 1'b0;
  endtask

  task automatic run_to_end(input int limit);
    cycles = 0;
    while (!(done || error) && cycles < limit) begin
      step();
      cycles++;
    end
  endtask

  task automatic push_image(input logic [7:0] bytes[], input logic [7:0] csum_override, input bit use_override);
    logic [7:0] s;
    s = 8'h00;
    foreach (bytes[i]) begin
      push(bytes[i]);
      if (i >= 4) s = s + bytes[i];
    end
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    push(use_override ? csum_override : s);
`else
    if (use_override) s = csum_override;
`endif
  endtask

  initial begin
    logic [7:0] img2[] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                           8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [7:0] img1[] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [7:0] img0[] = '{8'h00, 8'h00, 8'h00, 8'h00};
    vectors = 0; miscompares = 0;
    foreach (ram_m[i]) ram_m[i] = 32'h0;
    popped = 0; writes = 0; viol = 0; bad_we = 0; prev_pop = 1'b0;

    // Reset values
    @(negedge clk);
    step(); step();
    check("rst_rd_uart", 32'(rd_uart), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);

    // Two-word image, bytes back-to-back
    start_test();
    push_image(img2, 8'h00, 1'b0);
    run_to_end(500);
    $display("image N=2: cycles=%0d writes=%0d done=%0d", cycles, writes, done);
    check("n2_cycles", 32'(cycles), 32'(26 + CS));
    check("n2_ram0", ram_m[0], 32'h44332211);
    check("n2_ram1", ram_m[1], 32'hDDCCBBAA);
    check("n2_writes", 32'(writes), 32'd2);
    check("n2_we_full", 32'(bad_we), 32'd0);
    check("n2_done", 32'(done), 32'd1);
    check("n2_cpu_reset", 32'(cpu_reset), 32'd0);
    check("n2_busy", 32'(busy), 32'd0);
    check("n2_error", 32'(error), 32'd0);
    check("n2_pop_gap", 32'(viol), 32'd0);
    check("n2_popped", 32'(popped), 32'(12 + CS / 2));

    // Oversized header: N = NUM_WORDS + 1 = 3585
    start_test();
    push(8'h01); push(8'h0E); push(8'h00); push(8'h00);
    run_to_end(200);
    for (int i = 0; i < 6; i++) step();
    $display("oversize header: cycles=%0d error=%0d writes=%0d", cycles, error, writes);
    check("big_cycles", 32'(cycles), 32'd8);
    check("big_error", 32'(error), 32'd1);
    check("big_cpu_reset", 32'(cpu_reset), 32'd1);
    check("big_busy", 32'(busy), 32'd1);
    check("big_done", 32'(done), 32'd0);
    check("big_writes", 32'(writes), 32'd0);

    // Reset after 5 payload bytes, then a fresh one-word image
    start_test();
    push(8'h02); push(8'h00); push(8'h00); push(8'h00);
    push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'hAA);
    cycles = 0;
    while (popped < 9 && cycles < 200) begin step(); cycles++; end
    check("mid_popped", 32'(popped), 32'd9);
    check("mid_writes", 32'(writes), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd1);
    popped = 0; writes = 0; viol = 0;
    push_image(img1, 8'h00, 1'b0);
    run_to_end(500);
    $display("restart N=1: cycles=%0d ram0=%08h done=%0d", cycles, ram_m[0], done);
    check("rs_cycles", 32'(cycles), 32'(17 + CS));
    check("rs_ram0", ram_m[0], 32'hDEADBEEF);
    check("rs_writes", 32'(writes), 32'd1);
    check("rs_done", 32'(done), 32'd1);
    check("rs_pop_gap", 32'(viol), 32'd0);

`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    // Wrong trailing checksum byte
    start_test();
    push_image(img2, 8'h00, 1'b1);
    run_to_end(500);
    $display("bad checksum: error=%0d done=%0d ram0=%08h", error, done, ram_m[0]);
    check("cs_error", 32'(error), 32'd1);
    check("cs_done", 32'(done), 32'd0);
    check("cs_cpu_reset", 32'(cpu_reset), 32'd1);
    check("cs_ram0", ram_m[0], 32'h44332211);
    check("cs_ram1", ram_m[1], 32'hDDCCBBAA);
`endif

    // Empty image, extra bytes must stay in the FIFO
    start_test();
    push_image(img0, 8'h00, 1'b0);
    push(8'h55); push(8'h66);
    run_to_end(200);
    for (int i = 0; i < 10; i++) step();
    $display("empty image: cycles=%0d popped=%0d left=%0d done=%0d", cycles, popped, q.size(), done);
    check("z_cycles", 32'(cycles), 32'(8 + CS));
    check("z_done", 32'(done), 32'd1);
    check("z_writes", 32'(writes), 32'd0);
    check("z_popped", 32'(popped), 32'(4 + CS / 2));
    check("z_left", 32'(q.size()), 32'd2);
    check("z_rx_empty", 32'(rx_empty), 32'd0);
    check("z_rd_uart", 32'(rd_uart), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
